// File: rtl/morse_letter_scheduler_if.sv
// Requester handshakes and transmitter-side outputs of the Morse letter scheduler.
// The scheduler uses the slave modport; user logic and the transmitter see the master view.
interface morse_letter_scheduler_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          ReqA;
  logic [2:0]                    LetterA;
  logic                          AckA;
  logic                          ReqB;
  logic [2:0]                    LetterB;
  logic                          AckB;
  logic                          Start;
  logic [2:0]                    Letter;
  logic                          Busy;
  logic [$clog2(FIFO_DEPTH):0]   Count;

  modport master (
    output ReqA, LetterA, ReqB, LetterB,
    input  AckA, AckB, Start, Letter, Busy, Count
  );

  modport slave (
    input  ReqA, LetterA, ReqB, LetterB,
    output AckA, AckB, Start, Letter, Busy, Count
  );
endinterface

// File: rtl/morse_letter_scheduler.sv
// Two-requester round-robin front end for a Morse letter transmitter: letters are
// queued in a small FIFO and launched one at a time with a letter+gap holdoff.
module morse_letter_scheduler #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int FIFO_DEPTH      = 4,
  parameter int LETTER_PERIODS  = 12,
  parameter int GAP_PERIODS     = 3
) (
  input logic                     ClockIn,
  input logic                     Resetn,
  morse_letter_scheduler_if.slave bus
);
  localparam int PERIOD        = CLOCK_FREQUENCY / 2;
  localparam int LETTER_CYCLES = LETTER_PERIODS * PERIOD;
  localparam int TOTAL_CYCLES  = (LETTER_PERIODS + GAP_PERIODS) * PERIOD;
  localparam int PW            = $clog2(FIFO_DEPTH);
  localparam int CW            = PW + 1;
  localparam int TW            = $clog2(TOTAL_CYCLES + 1);

  localparam logic [TW-1:0] SEND_LAST = TW'(LETTER_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(TOTAL_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  logic [2:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [1:0]    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [1:0]    ack_reg;
  logic          last_b_reg;
  logic          start_reg, busy_reg;
  logic [2:0]    letter_reg;

  logic [1:0]    req_vec, elig, grant;
  logic          full, push, pop;
  logic [2:0]    push_letter;

  assign req_vec = {bus.ReqB, bus.ReqA};
  assign full    = (count_reg == CW'(FIFO_DEPTH));

  // A requester whose Ack is currently high is still dropping Req; skip it this cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = req_vec[gi] & ~ack_reg[gi];
    end
  endgenerate

  always_comb begin
    grant = 2'b00;
    if (!full) begin
      if (elig == 2'b11) begin
        grant = last_b_reg ? 2'b01 : 2'b10;
      end else begin
        grant = elig;
      end
    end
  end

  assign push        = |grant;
  assign push_letter = grant[1] ? bus.LetterB : bus.LetterA;

  // timer_reg equals the number of cycles since the LAUNCH cycle of the current letter.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_next = TW'(1);
        state_next = SEND;
      end
      SEND: begin
        timer_next = timer_reg + TW'(1);
        if (timer_reg == SEND_LAST) begin
          state_next = GAP;
        end
      end
      default: begin
        timer_next = timer_reg + TW'(1);
        if (timer_reg == GAP_LAST) begin
          timer_next = '0;
          if (count_reg != '0) begin
            pop        = 1'b1;
            state_next = LAUNCH;
          end else begin
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_letter;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (!Resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= IDLE;
      timer_reg  <= '0;
      ack_reg    <= 2'b00;
      last_b_reg <= 1'b1;
      start_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      letter_reg <= 3'b000;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
        last_b_reg <= grant[1];
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
        letter_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      state_reg <= state_next;
      timer_reg <= timer_next;
      ack_reg   <= grant;
      // Start and Busy are a registered view of the FSM, so they trail it by one cycle.
      start_reg <= (state_reg == LAUNCH);
      busy_reg  <= (state_reg != IDLE);
    end
  end

  assign bus.AckA   = ack_reg[0];
  assign bus.AckB   = ack_reg[1];
  assign bus.Start  = start_reg;
  assign bus.Letter = letter_reg;
  assign bus.Busy   = busy_reg;
  assign bus.Count  = count_reg;
endmodule
